pulse_evt_queue: RTL
====================

Name: pulse_evt_queue

Overview:
- Fast-domain front end that sits directly upstream of the pulse synchronizer.
- Accepts raw single-cycle event pulses, which may arrive back-to-back, and counts them as pending.
- Issues them one at a time as single-cycle pulses on sync_sig, and only when the synchronizer reports not busy.
- Because the synchronizer cannot accept a new pulse while busy, this block ensures no event is silently lost; lost events are flagged.

Parameters:
- CNT_W, 4: width of pending-event counter; maximum pending = 2^CNT_W-1.
- ACK_TO, 4: clk cycles allowed in WAIT_ACK for sync_busy to rise before a timeout is flagged; legal range 2..255.

Ports:
- clk  input  1  fast clock (synchronizer source domain).
- rst  input  1  asynchronous active-low reset.
- evt_in  input  1  event pulse; each high cycle is one event.
- sync_busy  input  1  busy from the downstream pulse synchronizer.
- clr_err  input  1  synchronous clear of the sticky flags.
- sync_sig  output  1  registered single-cycle pulse to the synchronizer's sig input.
- pending  output  CNT_W  events accepted but not yet issued.
- overflow  output  1  sticky; an event was dropped because pending was saturated.
- ack_timeout  output  1  sticky; sync_busy did not rise within ACK_TO cycles of a fire.
- idle  output  1  high when state is IDLE and pending == 0.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, pending = 0, sync_sig = 0, overflow = 0, ack_timeout = 0, idle = 1.
  - Reset mid-operation aborts any fire in progress; pending events are discarded.
- Pending counter, updated each clk edge:
  - inc = evt_in && (pending != max || dec).
  - dec = FSM transition IDLE -> FIRE.
  - inc and dec in the same cycle: pending unchanged.
  - evt_in while pending == max and no dec: event dropped, overflow <= 1.
  - No wrap-around in either direction; the counter never decrements below 0.
- FSM states: IDLE, FIRE, WAIT_ACK, WAIT_DONE.
  - IDLE: if pending != 0 and !sync_busy, go to FIRE. Otherwise stay.
  - FIRE: sync_sig = 1 for exactly this cycle (registered output, asserted on the edge entering FIRE). Unconditionally go to WAIT_ACK and load the timeout counter with ACK_TO-1.
  - WAIT_ACK: if sync_busy, go to WAIT_DONE. Else if the timeout counter == 0, set ack_timeout <= 1 and go to IDLE; the event counts as issued and is not re-fired. Else decrement the timeout counter.
  - WAIT_DONE: if !sync_busy, go to IDLE.
- Latency:
  - evt_in high at edge N with pending == 0 and the synchronizer idle: pending = 1 after edge N, sync_sig high during cycle N+2.
  - The downstream busy rises one cycle after sync_sig.
- Throughput: at most one fire per synchronizer busy window. Minimum spacing between sync_sig pulses = 3 cycles + busy duration.
- Arithmetic: the pending update is computed at CNT_W+1 bits and saturated; the timeout counter is 8 bits.
- clr_err:
  - Clears overflow and ack_timeout on the next edge.
  - If clr_err coincides with a new error event, the set wins.
  - Does not affect pending or state.
- idle is combinational from registered state and pending.
- sync_busy high in IDLE at power-up or after a timeout blocks firing until it falls. No other side effects.

Decomposition:
- Shared package pulse_sync_pkg holds:
  - the FSM state typedef (2-bit encoding IDLE=0, FIRE=1, WAIT_ACK=2, WAIT_DONE=3);
  - default CNT_W and ACK_TO constants;
  - the timeout counter width constant (8).
- One sub-module is natural: sat_updown_cnt.
  - Parameterised width; inputs inc and dec; outputs count and sat.
  - Async active-low reset.
  - Holds the pending counter and flags the saturated-drop condition.

Test Plan:
- Single event: evt_in high 1 cycle at edge 10, sync_busy modelled as rising 1 cycle after sync_sig and lasting 6 cycles. Required: sync_sig high only in cycle 12; pending 1 -> 0; idle returns high after busy falls.
- Burst: evt_in high 5 consecutive cycles. Required: pending peaks at 4 (one fire overlaps the burst), 5 sync_sig pulses total, each one cycle wide, none while sync_busy = 1; overflow stays 0.
- Saturation, CNT_W = 2, sync_busy held high: 5 events. Required: pending = 3, overflow = 1. After busy is released, exactly 3 pulses issue.
- Timeout: sync_busy tied low after fire. Required: ack_timeout = 1 ACK_TO cycles after sync_sig, FSM back in IDLE, next pending event still fires; clr_err then clears ack_timeout.
- Simultaneous inc/dec at pending == max: evt_in high on the IDLE -> FIRE edge. Required: pending unchanged at max, overflow stays 0.
- Reset mid-operation: rst low during WAIT_DONE with pending = 2. Required: all outputs at reset values immediately (asynchronous); no sync_sig after rst is released until a new event arrives.

Source files
------------

// File: rtl/pulse_sync_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pulse_sync_pkg : shared types/constants for the pulse event queue   |
// | rev 1.0                                                              |
// +--------------------------------------------------------------------+
package pulse_sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FIRE      = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  localparam int C_DEF_CNT_W  = 4;
  localparam int C_DEF_ACK_TO = 4;
  localparam int C_TMR_W      = 8;

endpackage
`default_nettype wire

// File: rtl/sat_updown_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sat_updown_cnt : saturating up/down counter with drop flag          |
// | rev 1.0                                                              |
// +--------------------------------------------------------------------+
module sat_updown_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         sat
);

  localparam logic [W:0] C_ONE = (W+1)'(1);

  logic [W-1:0] r_count;
  logic [W:0]   w_sum;

  // One extra bit exposes the overflow that a full counter would wrap into.
  always_comb begin
    w_sum = {1'b0, r_count};
    if (inc && !dec) begin
      w_sum = w_sum + C_ONE;
    end else if (dec && !inc && (r_count != '0)) begin
      w_sum = w_sum - C_ONE;
    end
  end

  assign sat   = w_sum[W];
  assign count = r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (!w_sum[W]) begin
      r_count <= w_sum[W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/pulse_evt_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pulse_evt_queue : queues event pulses and issues them one at a time |
// | rev 1.0                                                              |
// +--------------------------------------------------------------------+
module pulse_evt_queue
  import pulse_sync_pkg::*;
#(
  parameter int CNT_W  = C_DEF_CNT_W,
  parameter int ACK_TO = C_DEF_ACK_TO
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             evt_in,
  input  logic             sync_busy,
  input  logic             clr_err,
  output logic             sync_sig,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  output logic             ack_timeout,
  output logic             idle
);

  localparam logic [C_TMR_W-1:0] C_TMR_LOAD = C_TMR_W'(ACK_TO - 1);
  localparam logic [C_TMR_W-1:0] C_TMR_ONE  = C_TMR_W'(1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [C_TMR_W-1:0]   r_tmr;
  logic [C_TMR_W-1:0]   w_tmr_nxt;
  logic                 w_fire_go;
  logic                 w_tmo_evt;
  logic                 w_drop;
  logic [CNT_W-1:0]     w_pending;
  logic                 r_sync_sig;
  logic                 r_overflow;
  logic                 r_ack_timeout;

  sat_updown_cnt #(
    .W (CNT_W)
  ) u_pend_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (evt_in),
    .dec   (w_fire_go),
    .count (w_pending),
    .sat   (w_drop)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_fire_go   = 1'b0;
    w_tmo_evt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((w_pending != '0) && !sync_busy) begin
          w_state_nxt = ST_FIRE;
          w_fire_go   = 1'b1;
        end
      end
      ST_FIRE: begin
        w_state_nxt = ST_WAIT_ACK;
        w_tmr_nxt   = C_TMR_LOAD;
      end
      ST_WAIT_ACK: begin
        // A missing ack still consumes the event; it is never re-fired.
        if (sync_busy) begin
          w_state_nxt = ST_WAIT_DONE;
        end else if (r_tmr == '0) begin
          w_state_nxt = ST_IDLE;
          w_tmo_evt   = 1'b1;
        end else begin
          w_tmr_nxt = r_tmr - C_TMR_ONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!sync_busy) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_tmr         <= '0;
      r_sync_sig    <= 1'b0;
      r_overflow    <= 1'b0;
      r_ack_timeout <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tmr      <= w_tmr_nxt;
      r_sync_sig <= w_fire_go;
      // Set has priority over clear on the sticky flags.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_err) begin
        r_overflow <= 1'b0;
      end
      if (w_tmo_evt) begin
        r_ack_timeout <= 1'b1;
      end else if (clr_err) begin
        r_ack_timeout <= 1'b0;
      end
    end
  end

  assign sync_sig    = r_sync_sig;
  assign pending     = w_pending;
  assign overflow    = r_overflow;
  assign ack_timeout = r_ack_timeout;
  assign idle        = (r_state == ST_IDLE) && (w_pending == '0);

endmodule
`default_nettype wire
